// File: rtl/seq_det_pkg.sv
// Shared constants and types for the serial pattern detector.
// state_t documents the two-state Mealy view of the default "11" detector.
package seq_det_pkg;

  localparam int         DEF_N       = 2;
  localparam logic [1:0] DEF_PATTERN = 2'b11;

  // S_A: last sample 0 (or none yet), S_B: last sample 1.
  typedef enum logic {
    S_A = 1'b0,
    S_B = 1'b1
  } state_t;

  // Width of a counter that saturates at n-1 (never narrower than 1 bit).
  function automatic int fill_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_shift_hist.sv
// Sample history shift register plus a saturating count of valid samples.
// hist_o[0] is the most recent sample; full_o means N-1 samples have been taken.
module seq_shift_hist
  import seq_det_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         w_i,
  output logic [N-2:0] hist_o,
  output logic         full_o
);

  localparam int             FW       = fill_width(N);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

  logic [N-2:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;

  generate
    if (N == 2) begin : g_single
      assign hist_d = w_i;
    end else begin : g_shift
      assign hist_d = {hist_q[N-3:0], w_i};
    end
  endgenerate

  assign fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign full_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/sequence_detector_2.sv
// Serial bit-pattern detector: z is a Mealy output comparing the last N-1
// samples plus the live w against PATTERN (MSB oldest, LSB is current w).
module sequence_detector_2
  import seq_det_pkg::*;
#(
  parameter int           N       = DEF_N,
  parameter logic [N-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic resetn,
  input  logic w,
  output logic z
);

  logic [N-2:0] hist;
  logic         full;

  seq_shift_hist #(
    .N(N)
  ) u_hist (
    .clk_i   (clk),
    .resetn_i(resetn),
    .w_i     (w),
    .hist_o  (hist),
    .full_o  (full)
  );

  // Gating on full keeps the cleared history from matching zero-bearing
  // patterns right after reset; every cycle is judged on its own, so
  // overlapping matches fall out naturally.
  assign z = full && ({hist, w} == PATTERN);

endmodule

// File: tb/tb_sequence_detector_2.sv
// Directed bench for sequence_detector_2: default "11" detector, a 4-bit
// "1011" instance and a 3-bit "001" instance that exercises fill gating.
module tb_sequence_detector_2;

  typedef struct packed {
    logic rst;
    logic w;
    logic z;
  } vec_t;

  logic clk;
  logic rst2, w2, z2;
  logic rst4, w4, z4;
  logic rst3, w3, z3;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  vec_t v2[16];
  vec_t v4[9];
  vec_t v3[6];

  sequence_detector_2 dut2 (
    .clk   (clk),
    .resetn(rst2),
    .w     (w2),
    .z     (z2)
  );

  sequence_detector_2 #(
    .N      (4),
    .PATTERN(4'b1011)
  ) dut4 (
    .clk   (clk),
    .resetn(rst4),
    .w     (w4),
    .z     (z4)
  );

  sequence_detector_2 #(
    .N      (3),
    .PATTERN(3'b001)
  ) dut3 (
    .clk   (clk),
    .resetn(rst3),
    .w     (w3),
    .z     (z3)
  );

  // Clock: 10-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cur_z(input int sel);
    case (sel)
      4:       return z4;
      3:       return z3;
      default: return z2;
    endcase
  endfunction

  task automatic check(input string nm, input logic act);
    logic e;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: z=%b expected %b at t=%0t", nm, act, e, $time);
    end
  endtask

  task automatic expect_z(input int sel, input string nm, input logic e);
    exp_q.push_back(e);
    check(nm, cur_z(sel));
  endtask

  // Drive one vector at the falling edge, check z two units later
  // (before the rising edge that samples this w).
  task automatic apply(input int sel, input vec_t v, input string nm);
    @(negedge clk);
    case (sel)
      4:       begin rst4 = v.rst; w4 = v.w; end
      3:       begin rst3 = v.rst; w3 = v.w; end
      default: begin rst2 = v.rst; w2 = v.w; end
    endcase
    #2;
    expect_z(sel, nm, v.z);
  endtask

  initial begin
    rst2 = 1'b0; w2 = 1'b0;
    rst4 = 1'b0; w4 = 1'b0;
    rst3 = 1'b0; w3 = 1'b0;

    // Default detector: fields are {resetn, w, expected z}.
    v2[0]  = '{1'b0, 1'b1, 1'b0};
    v2[1]  = '{1'b0, 1'b1, 1'b0};
    v2[2]  = '{1'b0, 1'b1, 1'b0};
    v2[3]  = '{1'b1, 1'b1, 1'b0};
    v2[4]  = '{1'b1, 1'b1, 1'b1};
    v2[5]  = '{1'b1, 1'b0, 1'b0};
    v2[6]  = '{1'b1, 1'b0, 1'b0};
    v2[7]  = '{1'b1, 1'b1, 1'b0};
    v2[8]  = '{1'b1, 1'b0, 1'b0};
    v2[9]  = '{1'b1, 1'b0, 1'b0};
    v2[10] = '{1'b1, 1'b1, 1'b0};
    v2[11] = '{1'b1, 1'b1, 1'b1};
    v2[12] = '{1'b1, 1'b1, 1'b1};
    v2[13] = '{1'b1, 1'b0, 1'b0};
    v2[14] = '{1'b1, 1'b1, 1'b0};
    v2[15] = '{1'b1, 1'b0, 1'b0};

    // N=4, 1011: stream 0,1,0,1,1,0,1,1 matches at positions 5 and 8.
    v4[0] = '{1'b0, 1'b1, 1'b0};
    v4[1] = '{1'b1, 1'b0, 1'b0};
    v4[2] = '{1'b1, 1'b1, 1'b0};
    v4[3] = '{1'b1, 1'b0, 1'b0};
    v4[4] = '{1'b1, 1'b1, 1'b0};
    v4[5] = '{1'b1, 1'b1, 1'b1};
    v4[6] = '{1'b1, 1'b0, 1'b0};
    v4[7] = '{1'b1, 1'b1, 1'b0};
    v4[8] = '{1'b1, 1'b1, 1'b1};

    // N=3, 001: {00,1} is seen with only one valid sample and must not match.
    v3[0] = '{1'b0, 1'b1, 1'b0};
    v3[1] = '{1'b1, 1'b0, 1'b0};
    v3[2] = '{1'b1, 1'b1, 1'b0};
    v3[3] = '{1'b1, 1'b0, 1'b0};
    v3[4] = '{1'b1, 1'b0, 1'b0};
    v3[5] = '{1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 16; i++) apply(2, v2[i], $sformatf("d2_vec%0d", i));
    for (int i = 0; i < 9; i++)  apply(4, v4[i], $sformatf("d4_vec%0d", i));
    for (int i = 0; i < 6; i++)  apply(3, v3[i], $sformatf("d3_vec%0d", i));

    // Long idle with w=0: no match may appear.
    for (int i = 0; i < 20; i++) apply(2, '{1'b1, 1'b0, 1'b0}, $sformatf("d2_idle%0d", i));

    // Combinational response to w within one cycle, history = 1.
    apply(2, '{1'b1, 1'b1, 1'b0}, "d2_load1");
    @(negedge clk);
    w2 = 1'b1;
    #1 expect_z(2, "d2_comb_hi", 1'b1);
    w2 = 1'b0;
    #1 expect_z(2, "d2_comb_lo", 1'b0);
    w2 = 1'b1;
    #1 expect_z(2, "d2_comb_hi2", 1'b1);

    // Mid-stream reset pulse between edges while w=1.
    @(negedge clk);
    w2 = 1'b1;
    #1 expect_z(2, "d2_pre_rst", 1'b1);
    rst2 = 1'b0;
    #1 expect_z(2, "d2_async_rst", 1'b0);
    rst2 = 1'b1;
    #1 expect_z(2, "d2_post_release", 1'b0);
    apply(2, '{1'b1, 1'b1, 1'b1}, "d2_one_edge_after");
    apply(2, '{1'b1, 1'b0, 1'b0}, "d2_fall");

    // Reset held across an edge: history must not survive.
    apply(2, '{1'b1, 1'b1, 1'b0}, "d2_load2");
    apply(2, '{1'b0, 1'b1, 1'b0}, "d2_rst_hold");
    apply(2, '{1'b1, 1'b1, 1'b0}, "d2_rst_cleared");
    apply(2, '{1'b1, 1'b1, 1'b1}, "d2_refill");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain: %0d left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
